// File: rtl/hyperbus_tx_serializer.sv
// hyperbus_tx_serializer: splits AXI W beats into 16-bit PHY words. Only the
// word range [first, last] of each beat is emitted. Consecutive beats follow
// each other with no bubble.
// Ports:
//   clk_i, rst_ni                     clock, async active-low reset
//   clear_i                           sync abort: drop the buffered beat, return to IDLE
//   w_data_i/w_strb_i/w_last_i        beat payload and end-of-burst flag
//   w_first_word_i/w_last_word_i      inclusive word range to emit
//   w_valid_i/w_ready_o               beat handshake (w_ready_o is combinational)
//   tx_o/tx_valid_o/tx_ready_i        16-bit word handshake toward the TX FIFO
//   busy_o                            a beat is buffered
package hyperbus_pkg;
  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  strb;
    logic        last;
  } hyper_tx_t;
endpackage

module hyperbus_tx_serializer
  import hyperbus_pkg::*;
#(
  parameter  int unsigned AxiDataWidth = 64,
  localparam int unsigned NumWords     = AxiDataWidth / 16,
  localparam int unsigned WordIdxWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
  localparam int unsigned StrbWidth    = AxiDataWidth / 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic [AxiDataWidth-1:0] w_data_i,
  input  logic [StrbWidth-1:0]    w_strb_i,
  input  logic                    w_last_i,
  input  logic [WordIdxWidth-1:0] w_first_word_i,
  input  logic [WordIdxWidth-1:0] w_last_word_i,
  input  logic                    w_valid_i,
  output logic                    w_ready_o,
  output hyper_tx_t               tx_o,
  output logic                    tx_valid_o,
  input  logic                    tx_ready_i,
  output logic                    busy_o
);

  typedef enum logic {IDLE = 1'b0, SER = 1'b1} state_e;

  state_e                  r_state;
  logic [AxiDataWidth-1:0] r_data;
  logic [StrbWidth-1:0]    r_strb;
  logic                    r_last;
  logic [WordIdxWidth-1:0] r_idx;
  logic [WordIdxWidth-1:0] r_end;
  hyper_tx_t               r_tx;
  logic                    r_tx_valid;
  logic                    r_busy;

  logic [WordIdxWidth-1:0] w_end_in;
  logic [WordIdxWidth-1:0] w_idx_nxt;
  logic                    w_at_end;

  // Select 16-bit word idx of a beat.
  function automatic logic [15:0] sel_data(input logic [AxiDataWidth-1:0] d,
                                           input logic [WordIdxWidth-1:0] idx);
    logic [15:0] res;
    res = '0;
    for (int unsigned i = 0; i < NumWords; i++) begin
      if (idx == WordIdxWidth'(i)) res = d[16*i +: 16];
    end
    return res;
  endfunction

  // Select the 2 strobe bits belonging to word idx.
  function automatic logic [1:0] sel_strb(input logic [StrbWidth-1:0] s,
                                          input logic [WordIdxWidth-1:0] idx);
    logic [1:0] res;
    res = '0;
    for (int unsigned i = 0; i < NumWords; i++) begin
      if (idx == WordIdxWidth'(i)) res = s[2*i +: 2];
    end
    return res;
  endfunction

  // An inverted range collapses to a single word at the first index.
  assign w_end_in  = (w_first_word_i > w_last_word_i) ? w_first_word_i : w_last_word_i;
  assign w_at_end  = (r_idx == r_end);
  assign w_idx_nxt = r_idx + WordIdxWidth'(1);

  // Ready in IDLE, or in SER when the final word of the beat is leaving.
  assign w_ready_o = !clear_i &&
                     ((r_state == IDLE) || (tx_ready_i && w_at_end));

  // Serializer FSM; the output word is registered and preloaded one step ahead.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_data     <= '0;
      r_strb     <= '0;
      r_last     <= 1'b0;
      r_idx      <= '0;
      r_end      <= '0;
      r_tx       <= '0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
    end else if (clear_i) begin
      r_state    <= IDLE;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      if (w_valid_i && w_ready_o) begin
        r_state    <= SER;
        r_data     <= w_data_i;
        r_strb     <= w_strb_i;
        r_last     <= w_last_i;
        r_idx      <= w_first_word_i;
        r_end      <= w_end_in;
        r_tx.data  <= sel_data(w_data_i, w_first_word_i);
        r_tx.strb  <= sel_strb(w_strb_i, w_first_word_i);
        r_tx.last  <= w_last_i && (w_first_word_i == w_end_in);
        r_tx_valid <= 1'b1;
        r_busy     <= 1'b1;
      end else if (r_state == SER && tx_ready_i) begin
        if (!w_at_end) begin
          r_idx     <= w_idx_nxt;
          r_tx.data <= sel_data(r_data, w_idx_nxt);
          r_tx.strb <= sel_strb(r_strb, w_idx_nxt);
          r_tx.last <= r_last && (w_idx_nxt == r_end);
        end else begin
          r_state    <= IDLE;
          r_tx_valid <= 1'b0;
          r_busy     <= 1'b0;
        end
      end
    end
  end

  assign tx_o       = r_tx;
  assign tx_valid_o = r_tx_valid;
  assign busy_o     = r_busy;

endmodule

// File: tb/tb_hyperbus_tx_serializer.sv
// Self-checking bench for hyperbus_tx_serializer (64-bit beats, 4 words/beat).
module tb_hyperbus_tx_serializer;
  import hyperbus_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        w_last;
  logic [1:0]  w_first_word;
  logic [1:0]  w_last_word;
  logic        w_valid;
  logic        w_ready;
  hyper_tx_t   tx;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  hyperbus_tx_serializer #(.AxiDataWidth(64)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .clear_i       (clear),
    .w_data_i      (w_data),
    .w_strb_i      (w_strb),
    .w_last_i      (w_last),
    .w_first_word_i(w_first_word),
    .w_last_word_i (w_last_word),
    .w_valid_i     (w_valid),
    .w_ready_o     (w_ready),
    .tx_o          (tx),
    .tx_valid_o    (tx_valid),
    .tx_ready_i    (tx_ready),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]      data;
    logic [7:0]       strb;
    logic [1:0]       first;
    logic [1:0]       lastw;
    logic             wlast;
    int               n;
    logic [3:0][15:0] exp_data;
    logic [3:0][1:0]  exp_strb;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input vec_t v);
    w_data       = v.data;
    w_strb       = v.strb;
    w_last       = v.wlast;
    w_first_word = v.first;
    w_last_word  = v.lastw;
    w_valid      = 1'b1;
  endtask

  // Send one beat with tx_ready=1 and check every emitted word, then IDLE.
  task automatic run_vec(input int vi);
    vec_t v;
    v = vecs[vi];
    tx_ready = 1'b1;
    drive_beat(v);
    #1;
    chk($sformatf("v%0d accept_ready", vi), 64'(w_ready), 64'd1);
    cyc();
    w_valid = 1'b0;
    for (int k = 0; k < v.n; k++) begin
      #1;
      chk($sformatf("v%0d w%0d valid", vi, k), 64'(tx_valid), 64'd1);
      chk($sformatf("v%0d w%0d busy", vi, k), 64'(busy), 64'd1);
      chk($sformatf("v%0d w%0d data", vi, k), 64'(tx.data), 64'(v.exp_data[k]));
      chk($sformatf("v%0d w%0d strb", vi, k), 64'(tx.strb), 64'(v.exp_strb[k]));
      chk($sformatf("v%0d w%0d last", vi, k), 64'(tx.last),
          64'(v.wlast && (k == v.n - 1)));
      chk($sformatf("v%0d w%0d wready", vi, k), 64'(w_ready), 64'(k == v.n - 1));
      cyc();
    end
    #1;
    chk($sformatf("v%0d idle_valid", vi), 64'(tx_valid), 64'd0);
    chk($sformatf("v%0d idle_wready", vi), 64'(w_ready), 64'd1);
  endtask

  initial begin
    vecs[0] = '{64'h4444_3333_2222_1111, 8'hFF, 2'd0, 2'd3, 1'b1, 4,
                64'h4444_3333_2222_1111, 8'hFF};
    vecs[1] = '{64'h4444_3333_2222_1111, 8'h30, 2'd2, 2'd2, 1'b0, 1,
                64'h0000_0000_0000_3333, 8'h03};
    vecs[2] = '{64'hDDDD_CCCC_BBBB_AAAA, 8'h64, 2'd1, 2'd2, 1'b1, 2,
                64'h0000_0000_CCCC_BBBB, 8'h09};
    vecs[3] = '{64'hDDDD_CCCC_BBBB_AAAA, 8'h64, 2'd3, 2'd1, 1'b1, 1,
                64'h0000_0000_0000_DDDD, 8'h01};
    vecs[4] = '{64'h0000_0000_5678_1234, 8'h00, 2'd0, 2'd1, 1'b0, 2,
                64'h0000_0000_5678_1234, 8'h00};
    vecs[5] = '{64'hFEDC_0000_0000_0000, 8'h80, 2'd3, 2'd3, 1'b1, 1,
                64'h0000_0000_0000_FEDC, 8'h02};
    vecs[6] = '{64'h4444_3333_2222_1111, 8'h01, 2'd0, 2'd0, 1'b1, 1,
                64'h0000_0000_0000_1111, 8'h01};

    rst_n = 1'b0; clear = 1'b0; w_data = '0; w_strb = '0; w_last = 1'b0;
    w_first_word = '0; w_last_word = '0; w_valid = 1'b0; tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst tx_valid", 64'(tx_valid), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst tx", 64'(tx), 64'd0);
    chk("rst w_ready", 64'(w_ready), 64'd1);
    rst_n = 1'b1;
    cyc();

    for (int i = 0; i < 7; i++) run_vec(i);

    // Back-to-back beats: 8 words, no bubble, last only on the 8th word.
    begin
      logic [7:0][15:0] exp_w;
      exp_w = 128'h8888_7777_6666_5555_4444_3333_2222_1111;
      tx_ready = 1'b1;
      w_data = 64'h4444_3333_2222_1111; w_strb = 8'hFF; w_last = 1'b0;
      w_first_word = 2'd0; w_last_word = 2'd3; w_valid = 1'b1;
      cyc();
      w_data = 64'h8888_7777_6666_5555; w_last = 1'b1;
      for (int k = 0; k < 8; k++) begin
        #1;
        chk($sformatf("b2b w%0d valid", k), 64'(tx_valid), 64'd1);
        chk($sformatf("b2b w%0d data", k), 64'(tx.data), 64'(exp_w[k]));
        chk($sformatf("b2b w%0d last", k), 64'(tx.last), 64'(k == 7));
        chk($sformatf("b2b w%0d wready", k), 64'(w_ready), 64'(k == 3 || k == 7));
        cyc();
        if (k == 3) w_valid = 1'b0;
      end
      #1;
      chk("b2b idle", 64'(tx_valid), 64'd0);
    end

    // Backpressure: tx_ready pattern 1,0,0,1,... across one 4-word beat.
    begin
      logic [9:0] pat;
      int w;
      pat = 10'b10_0100_1001;
      w = 0;
      drive_beat(vecs[0]);
      cyc();
      w_valid = 1'b0;
      for (int c = 0; c < 10 && w < 4; c++) begin
        tx_ready = pat[c];
        #1;
        chk($sformatf("bp c%0d valid", c), 64'(tx_valid), 64'd1);
        chk($sformatf("bp c%0d data", c), 64'(tx.data), 64'(vecs[0].exp_data[w]));
        chk($sformatf("bp c%0d wready", c), 64'(w_ready), 64'(pat[c] && w == 3));
        if (pat[c]) w++;
        cyc();
      end
      chk("bp all_words", 64'(w), 64'd4);
      tx_ready = 1'b1;
      #1;
      chk("bp idle", 64'(tx_valid), 64'd0);
    end

    // clear_i after the second word; next beat starts at its own first word.
    drive_beat(vecs[0]);
    tx_ready = 1'b1;
    cyc();
    w_valid = 1'b0;
    cyc();
    cyc();
    clear = 1'b1;
    drive_beat(vecs[2]);
    #1;
    chk("clr w_ready_low", 64'(w_ready), 64'd0);
    chk("clr still_3333", 64'(tx.data), 64'h3333);
    cyc();
    clear = 1'b0;
    w_valid = 1'b0;
    #1;
    chk("clr tx_valid", 64'(tx_valid), 64'd0);
    chk("clr busy", 64'(busy), 64'd0);
    chk("clr w_ready", 64'(w_ready), 64'd1);
    run_vec(2);

    // Async reset between edges in the middle of a beat.
    drive_beat(vecs[0]);
    cyc();
    w_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst tx_valid", 64'(tx_valid), 64'd0);
    chk("arst busy", 64'(busy), 64'd0);
    chk("arst tx", 64'(tx), 64'd0);
    chk("arst w_ready", 64'(w_ready), 64'd1);
    cyc();
    rst_n = 1'b1;
    cyc();
    run_vec(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
